// File: rtl/gray_decoder_stream_pkg.sv
// Shared definitions for the Gray-code receive path: step-direction encodings
// and default widths.
package gray_decoder_stream_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_CNT_W = 8;

    typedef enum logic [1:0] {
        DIR_HOLD = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10,
        DIR_JUMP = 2'b11
    } dir_t;

endpackage

// File: rtl/gray_to_bin.sv
// Purely combinational Gray-to-binary converter, usable by any receiver.
module gray_to_bin
    import gray_decoder_stream_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Binary bit i is the XOR of all Gray bits from i up to the MSB.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^(gray >> i);
    end

endmodule

// File: rtl/gray_decoder_stream.sv
// Registered Gray-code stream decoder with step-direction classification
// and a saturating count of illegal multi-bit transitions.
module gray_decoder_stream
    import gray_decoder_stream_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_gray,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_bin,
    output logic [1:0]       out_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             step_err,
    output logic [CNT_W-1:0] err_count
);

    logic [WIDTH-1:0] prev_gray;
    logic             have_prev;
    logic [WIDTH-1:0] bin_new;
    logic [WIDTH-1:0] diff;
    logic             diff_zero;
    logic             diff_single;
    logic             accept;
    dir_t             dir_next;
    logic             err_next;

    gray_to_bin #(.WIDTH(WIDTH)) u_gray_to_bin (
        .gray (in_gray),
        .bin  (bin_new)
    );

    assign in_ready    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready;
    assign diff        = in_gray ^ prev_gray;
    assign diff_zero   = (diff == '0);
    assign diff_single = !diff_zero && ((diff & (diff - WIDTH'(1))) == '0);

    // out_bin always holds the decode of prev_gray (both reset to zero and
    // both update on every accept), so it doubles as the previous binary value.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        dir_next = DIR_JUMP;
        err_next = 1'b0;
        if (have_prev) begin
            if (diff_zero) begin
                dir_next = DIR_HOLD;
            end else if (diff_single) begin
                if (bin_new == out_bin + WIDTH'(1)) begin
                    dir_next = DIR_UP;
                end else if (bin_new == out_bin - WIDTH'(1)) begin
                    dir_next = DIR_DOWN;
                end
            end else begin
                err_next = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_bin   <= '0;
            out_dir   <= DIR_HOLD;
            out_valid <= 1'b0;
            step_err  <= 1'b0;
            err_count <= '0;
            prev_gray <= '0;
            have_prev <= 1'b0;
        end else begin
            step_err <= 1'b0;
            if (accept) begin
                out_bin   <= bin_new;
                out_dir   <= dir_next;
                out_valid <= 1'b1;
                step_err  <= err_next;
                prev_gray <= in_gray;
                have_prev <= 1'b1;
                if (err_next && (err_count != '1)) begin
                    err_count <= err_count + CNT_W'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gray_decoder_stream.sv
// Scoreboard bench for gray_decoder_stream: directed Gray vectors with
// hand-computed binary/direction/error expectations, checked by a monitor.
module tb_gray_decoder_stream;
    import gray_decoder_stream_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;

    typedef struct packed {
        logic [WIDTH-1:0] bin;
        logic [1:0]       dir;
        logic             err;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] in_gray = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] out_bin;
    logic [1:0]       out_dir;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             step_err;
    logic [CNT_W-1:0] err_count;

    int n_cmp  = 0;
    int n_fail = 0;

    exp_t exp_q[$];

    gray_decoder_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_gray   (in_gray),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_bin   (out_bin),
        .out_dir   (out_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .step_err  (step_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per accepted code and checks the outputs
    // every cycle it is presented, so stalled outputs must also hold steady.
    exp_t             cur;
    bit               have_cur   = 1'b0;
    bit               fresh      = 1'b0;
    bit               reset_next = 1'b0;
    logic [CNT_W-1:0] cnt_exp    = '0;

    always @(negedge clk) begin
        if (reset_next) begin
            have_cur = 1'b0;
            cnt_exp  = '0;
        end
        if (fresh) begin
            if (exp_q.size() == 0) begin
                check("output_without_input", exp_q.size(), 1);
            end else begin
                cur      = exp_q.pop_front();
                have_cur = 1'b1;
                cnt_exp  = cur.cnt;
            end
            check("step_err_on_update", step_err, have_cur ? cur.err : 1'b0);
        end else begin
            check("step_err_idle", step_err, 1'b0);
        end
        check("out_valid", out_valid, have_cur);
        check("in_ready", in_ready, !have_cur || out_ready);
        check("err_count", err_count, cnt_exp);
        if (have_cur) begin
            check("out_bin", out_bin, cur.bin);
            check("out_dir", out_dir, cur.dir);
        end
        if (have_cur && out_ready) have_cur = 1'b0;
        fresh      = in_valid && in_ready && !rst;
        reset_next = rst;
    end

    task automatic issue(input logic [3:0] g, input logic [3:0] b, input logic [1:0] d,
                         input logic e, input logic [1:0] c);
        exp_t x;
        x.bin = b; x.dir = d; x.err = e; x.cnt = c;
        exp_q.push_back(x);
        in_gray  = g;
        in_valid = 1'b1;
    endtask

    task automatic wait_accept();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        check("accept_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [3:0] g, input logic [3:0] b, input logic [1:0] d,
                        input logic e, input logic [1:0] c);
        issue(g, b, d, e, c);
        wait_accept();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_bin", out_bin, 4'd0);
        check("rst_out_dir", out_dir, 2'b00);
        check("rst_step_err", step_err, 1'b0);
        check("rst_err_count", err_count, 2'd0);
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    logic [3:0] sweep [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                               4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state();

        // Ascending sweep: first code is a jump, every later one steps up.
        for (int i = 0; i < 16; i++) begin
            send(sweep[i], 4'(i), (i == 0) ? 2'b11 : 2'b01, 1'b0, 2'd0);
        end

        // Wrap in both directions.
        send(4'b0000, 4'd0,  2'b01, 1'b0, 2'd0);
        send(4'b1000, 4'd15, 2'b10, 1'b0, 2'd0);

        // Multi-bit jump, then a hold.
        send(4'b0000, 4'd0, 2'b01, 1'b0, 2'd0);
        send(4'b0001, 4'd1, 2'b01, 1'b0, 2'd0);
        send(4'b0111, 4'd5, 2'b11, 1'b1, 2'd1);
        send(4'b0111, 4'd5, 2'b00, 1'b0, 2'd1);
        idle(2);

        // Backpressure: one code lands, the next waits five stalled cycles.
        out_ready = 1'b0;
        send(4'b0101, 4'd6, 2'b01, 1'b0, 2'd1);
        issue(4'b0100, 4'd7, 2'b01, 1'b0, 2'd1);
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_out_bin", out_bin, 4'd6);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_accept();

        // Second error, then reset mid-stream.
        send(4'b0111, 4'd5, 2'b11, 1'b1, 2'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state();
        send(4'b0101, 4'd6, 2'b11, 1'b0, 2'd0);

        // Saturation of the 2-bit error counter.
        send(4'b0000, 4'd0, 2'b11, 1'b1, 2'd1);
        send(4'b0011, 4'd2, 2'b11, 1'b1, 2'd2);
        send(4'b0000, 4'd0, 2'b11, 1'b1, 2'd3);
        send(4'b0011, 4'd2, 2'b11, 1'b1, 2'd3);
        send(4'b0000, 4'd0, 2'b11, 1'b1, 2'd3);
        send(4'b0011, 4'd2, 2'b11, 1'b1, 2'd3);

        idle(4);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
